// File: rtl/e_mdu_pkg.sv
// Shared MD op encoding and default latencies for the E-stage multiply/divide unit.
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MDOP_NONE  = 4'd0,
    MDOP_MULT  = 4'd1,
    MDOP_MULTU = 4'd2,
    MDOP_DIV   = 4'd3,
    MDOP_DIVU  = 4'd4,
    MDOP_MTHI  = 4'd5,
    MDOP_MTLO  = 4'd6,
    MDOP_MFHI  = 4'd7,
    MDOP_MFLO  = 4'd8
  } mdop_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_md_start_op(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd4);
  endfunction

endpackage

// File: rtl/e_mdu_arith.sv
// Combinational 32x32 multiply/divide datapath producing {hi, lo} and a divide-by-zero hold flag.
module e_mdu_arith
  import e_mdu_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_hold
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_b_nz;
  logic [31:0] w_div_b;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_sq;
  logic [31:0] w_sr;
  logic [31:0] w_uq;
  logic [31:0] w_ur;

  // Sign-extended operands give the signed product in the low 64 bits of an unsigned multiply.
  assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
  assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

  // A zero divisor is swapped for one so the dividers never see x/0; the result is discarded.
  assign w_b_nz  = (i_b != 32'd0);
  assign w_div_b = w_b_nz ? i_b : 32'd1;
  assign w_abs_a = i_a[31] ? (32'd0 - i_a) : i_a;
  assign w_abs_b = w_div_b[31] ? (32'd0 - w_div_b) : w_div_b;
  assign w_sq    = w_abs_a / w_abs_b;
  assign w_sr    = w_abs_a % w_abs_b;
  assign w_uq    = i_a / w_div_b;
  assign w_ur    = i_a % w_div_b;

  // Result select per operation.
  always_comb begin
    o_hi   = 32'd0;
    o_lo   = 32'd0;
    o_hold = 1'b0;
    case (mdop_e'(i_op))
      MDOP_MULT:  {o_hi, o_lo} = w_prod_s;
      MDOP_MULTU: {o_hi, o_lo} = w_prod_u;
      MDOP_DIV: begin
        o_lo   = (i_a[31] ^ w_div_b[31]) ? (32'd0 - w_sq) : w_sq;
        o_hi   = i_a[31] ? (32'd0 - w_sr) : w_sr;
        o_hold = ~w_b_nz;
      end
      MDOP_DIVU: begin
        o_lo   = w_uq;
        o_hi   = w_ur;
        o_hold = ~w_b_nz;
      end
      default: begin
        o_hi   = 32'd0;
        o_lo   = 32'd0;
        o_hold = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: multi-cycle mult/div into HI/LO, mthi/mtlo/mfhi/mflo, D-stage stall.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDop,
  input  logic [31:0] E_V1,
  input  logic [31:0] E_V2,
  input  logic        D_MD,
  output logic        E_Busy,
  output logic [31:0] E_MDout,
  output logic        D_MDstall
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_hi_t;
  logic [31:0]      r_lo_t;
  logic             r_hold;

  logic [CNT_W-1:0] w_cnt_nxt;
  logic [31:0]      w_hi_nxt;
  logic [31:0]      w_lo_nxt;
  logic [31:0]      w_hi_t_nxt;
  logic [31:0]      w_lo_t_nxt;
  logic             w_hold_nxt;
  logic [31:0]      w_ar_hi;
  logic [31:0]      w_ar_lo;
  logic             w_ar_hold;
  logic             w_start;
  logic             w_is_div;
  md_state_e        w_state;

  e_mdu_arith u_arith (
    .i_op   (E_MDop),
    .i_a    (E_V1),
    .i_b    (E_V2),
    .o_hi   (w_ar_hi),
    .o_lo   (w_ar_lo),
    .o_hold (w_ar_hold)
  );

  assign w_state   = (r_cnt != '0) ? MD_BUSY : MD_IDLE;
  assign E_Busy    = (w_state == MD_BUSY);
  assign w_start   = is_md_start_op(E_MDop) & ~E_Busy;
  assign w_is_div  = (mdop_e'(E_MDop) == MDOP_DIV) || (mdop_e'(E_MDop) == MDOP_DIVU);
  assign D_MDstall = D_MD & (w_start | E_Busy);

  // HI/LO read mux; independent of busy so MF* during a stray busy cycle sees the old value.
  always_comb begin
    case (mdop_e'(E_MDop))
      MDOP_MFHI: E_MDout = r_hi;
      MDOP_MFLO: E_MDout = r_lo;
      default:   E_MDout = 32'd0;
    endcase
  end

  // Next-state: start latches the result, busy counts down, MT* only writes while idle.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_hi_nxt   = r_hi;
    w_lo_nxt   = r_lo;
    w_hi_t_nxt = r_hi_t;
    w_lo_t_nxt = r_lo_t;
    w_hold_nxt = r_hold;
    case (w_state)
      MD_IDLE: begin
        if (w_start) begin
          w_cnt_nxt  = w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          w_hi_t_nxt = w_ar_hi;
          w_lo_t_nxt = w_ar_lo;
          w_hold_nxt = w_ar_hold;
        end else if (mdop_e'(E_MDop) == MDOP_MTHI) begin
          w_hi_nxt = E_V1;
        end else if (mdop_e'(E_MDop) == MDOP_MTLO) begin
          w_lo_nxt = E_V1;
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      MD_BUSY: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if ((r_cnt == CNT_W'(1)) && !r_hold) begin
          w_hi_nxt = r_hi_t;
          w_lo_nxt = r_lo_t;
        end else begin
          w_hi_nxt = r_hi;
        end
      end
      default: w_cnt_nxt = '0;
    endcase
  end

  // State registers; reset clears everything so an in-flight op can never land afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
      r_hi_t <= 32'd0;
      r_lo_t <= 32'd0;
      r_hold <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_hi   <= w_hi_nxt;
      r_lo   <= w_lo_nxt;
      r_hi_t <= w_hi_t_nxt;
      r_lo_t <= w_lo_t_nxt;
      r_hold <= w_hold_nxt;
    end
  end

endmodule
